// File: rtl/if_id_decode.sv
// IF/ID stage: registers the fetched instruction and PC, decodes register selectors and
// control, and detects load-use hazards. Optional illegal-opcode flag: IF_ID_ILLEGAL_TRAP_EN.
module if_id_decode #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inValid,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   hazardStall,
    output logic                   outValid,
    output logic [PC_WIDTH-1:0]    pcOut,
    output logic [4:0]             register1,
    output logic [4:0]             register2,
    output logic [4:0]             writeRegister,
    output logic [31:0]            immediate,
    output logic                   regWrite,
    output logic                   memRead,
    output logic                   memWrite,
    output logic                   memToReg,
    output logic                   aluSrc,
    output logic                   branch,
    output logic                   jump,
    output logic [1:0]             aluOp
`ifdef IF_ID_ILLEGAL_TRAP_EN
    ,
    output logic                   illegalInstr
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    logic [5:0]  opcode;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic [31:0] d_imm;
    logic [4:0]  d_wr;
    logic        d_rw, d_mr, d_mw, d_m2r, d_as, d_br, d_jp, uses_rt;
    logic [1:0]  d_op;
`ifdef IF_ID_ILLEGAL_TRAP_EN
    logic        d_illegal;
`endif

    assign opcode = instruction[31:26];
    assign rs_in  = instruction[25:21];
    assign rt_in  = instruction[20:16];
    assign rd_in  = instruction[15:11];
    assign d_imm  = {{16{instruction[15]}}, instruction[15:0]};

    always_comb begin
        d_wr    = 5'd0;
        d_rw    = 1'b0;
        d_mr    = 1'b0;
        d_mw    = 1'b0;
        d_m2r   = 1'b0;
        d_as    = 1'b0;
        d_br    = 1'b0;
        d_jp    = 1'b0;
        d_op    = 2'b00;
        uses_rt = 1'b0;
`ifdef IF_ID_ILLEGAL_TRAP_EN
        d_illegal = 1'b0;
`endif
        case (opcode)
            OP_RTYPE: begin
                d_wr    = rd_in;
                d_rw    = 1'b1;
                d_op    = 2'b10;
                uses_rt = 1'b1;
            end
            OP_LW: begin
                d_wr  = rt_in;
                d_rw  = 1'b1;
                d_mr  = 1'b1;
                d_m2r = 1'b1;
                d_as  = 1'b1;
            end
            OP_SW: begin
                d_mw    = 1'b1;
                d_as    = 1'b1;
                uses_rt = 1'b1;
            end
            OP_BEQ: begin
                d_br    = 1'b1;
                d_op    = 2'b01;
                uses_rt = 1'b1;
            end
            OP_ADDI: begin
                d_wr = rt_in;
                d_rw = 1'b1;
                d_as = 1'b1;
            end
            OP_J: d_jp = 1'b1;
            default: begin
`ifdef IF_ID_ILLEGAL_TRAP_EN
                d_illegal = 1'b1;
`endif
            end
        endcase
        // writes to $0 are architecturally discarded
        if (d_wr == 5'd0)
            d_rw = 1'b0;
    end

    assign hazardStall = outValid & memRead & (writeRegister != 5'd0) & inValid &
                         ((rs_in == writeRegister) | (uses_rt & (rt_in == writeRegister)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset || (!reset && flush)) begin
            outValid      <= 1'b0;
            pcOut         <= '0;
            register1     <= 5'd0;
            register2     <= 5'd0;
            writeRegister <= 5'd0;
            immediate     <= 32'd0;
            regWrite      <= 1'b0;
            memRead       <= 1'b0;
            memWrite      <= 1'b0;
            memToReg      <= 1'b0;
            aluSrc        <= 1'b0;
            branch        <= 1'b0;
            jump          <= 1'b0;
            aluOp         <= 2'b00;
`ifdef IF_ID_ILLEGAL_TRAP_EN
            illegalInstr  <= 1'b0;
`endif
        end else if (!stall) begin
            if (hazardStall || !inValid) begin
                // bubble: fields and pc are kept, only validity and control drop
                outValid <= 1'b0;
                regWrite <= 1'b0;
                memRead  <= 1'b0;
                memWrite <= 1'b0;
                memToReg <= 1'b0;
                aluSrc   <= 1'b0;
                branch   <= 1'b0;
                jump     <= 1'b0;
                aluOp    <= 2'b00;
            end else begin
                outValid      <= 1'b1;
                pcOut         <= pc;
                register1     <= rs_in;
                register2     <= rt_in;
                writeRegister <= d_wr;
                immediate     <= d_imm;
                regWrite      <= d_rw;
                memRead       <= d_mr;
                memWrite      <= d_mw;
                memToReg      <= d_m2r;
                aluSrc        <= d_as;
                branch        <= d_br;
                jump          <= d_jp;
                aluOp         <= d_op;
`ifdef IF_ID_ILLEGAL_TRAP_EN
                illegalInstr  <= d_illegal;
`endif
            end
        end
    end

endmodule

// File: tb/tb_if_id_decode.sv
// Self-checking bench for if_id_decode: directed scenarios followed by random traffic
// compared against a spec-level model of the stage.
module tb_if_id_decode;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  r1, r2, wr;
        logic [31:0] imm;
        logic        rw, mr, mw, m2r, as, br, jp;
        logic [1:0]  op;
        logic        ill;
    } st_t;

`ifdef IF_ID_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, inValid, stall, flush;
    logic [31:0] instruction, pc;
    logic        hazardStall, outValid;
    logic [31:0] pcOut, immediate;
    logic [4:0]  register1, register2, writeRegister;
    logic        regWrite, memRead, memWrite, memToReg, aluSrc, branch, jump;
    logic [1:0]  aluOp;
    logic        ill_obs;
`ifdef IF_ID_ILLEGAL_TRAP_EN
    logic        illegalInstr;
    assign ill_obs = illegalInstr;
`else
    assign ill_obs = 1'b0;
`endif

    int   errors = 0;
    int   checks = 0;
    st_t  m;
    logic hz;

    if_id_decode #(.PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .inValid(inValid), .instruction(instruction),
        .pc(pc), .stall(stall), .flush(flush), .hazardStall(hazardStall),
        .outValid(outValid), .pcOut(pcOut), .register1(register1), .register2(register2),
        .writeRegister(writeRegister), .immediate(immediate), .regWrite(regWrite),
        .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg), .aluSrc(aluSrc),
        .branch(branch), .jump(jump), .aluOp(aluOp)
`ifdef IF_ID_ILLEGAL_TRAP_EN
        , .illegalInstr(illegalInstr)
`endif
    );

    always #5 clock = ~clock;

    function automatic st_t observed();
        st_t s;
        s = {outValid, pcOut, register1, register2, writeRegister, immediate,
             regWrite, memRead, memWrite, memToReg, aluSrc, branch, jump, aluOp, ill_obs};
        return s;
    endfunction

    // Spec decode table expressed as field assignments per instruction class.
    function automatic st_t decode(input logic [31:0] i, input logic [31:0] p);
        st_t s;
        int  opc;
        s       = '0;
        opc     = int'(i[31:26]);
        s.valid = 1'b1;
        s.pc    = p;
        s.r1    = i[25:21];
        s.r2    = i[20:16];
        s.imm   = 32'(signed'(i[15:0]));
        if (opc == 0)         begin s.wr = i[15:11]; s.rw = 1; s.op = 2; end
        else if (opc == 35)   begin s.wr = i[20:16]; s.rw = 1; s.mr = 1; s.m2r = 1; s.as = 1; end
        else if (opc == 43)   begin s.mw = 1; s.as = 1; end
        else if (opc == 4)    begin s.br = 1; s.op = 1; end
        else if (opc == 8)    begin s.wr = i[20:16]; s.rw = 1; s.as = 1; end
        else if (opc == 2)    s.jp = 1;
        else                  s.ill = TRAP;
        if (s.wr == 0) s.rw = 0;
        return s;
    endfunction

    function automatic logic model_hazard();
        logic reads_rt;
        reads_rt = (instruction[31:26] == 6'h00) || (instruction[31:26] == 6'h2B) ||
                   (instruction[31:26] == 6'h04);
        return m.valid && m.mr && (m.wr != 0) && inValid &&
               ((instruction[25:21] == m.wr) || (reads_rt && instruction[20:16] == m.wr));
    endfunction

    task automatic model_edge();
        if (flush) m = '0;
        else if (stall) m = m;
        else if (model_hazard() || !inValid) begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0;
            m.as = 0; m.br = 0; m.jp = 0; m.op = 0;
        end else m = decode(instruction, pc);
    endtask

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check(tag, 96'(observed()), 96'(m));
    endtask

    // Called at a falling edge; applies inputs, checks the combinational hazard, clocks once.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic st, input logic fl, output logic hz_seen);
        inValid = v; instruction = ins; pc = p; stall = st; flush = fl;
        #1;
        hz_seen = hazardStall;
        check("hazard", 96'(hazardStall), 96'(model_hazard()));
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_state("regs");
    endtask

    initial begin
        reset = 1; inValid = 0; instruction = 0; pc = 0; stall = 0; flush = 0;
        m = '0;
        #2;
        check_state("reset_regs");
        check("reset_hazard", 96'(hazardStall), 96'(0));
        @(negedge clock);
        reset = 0;

        step(1, 32'h0022_1820, 32'h40, 0, 0, hz);
        check("add_r1", 96'(register1), 96'(1));
        check("add_r2", 96'(register2), 96'(2));
        check("add_wr", 96'(writeRegister), 96'(3));
        check("add_rw_op", 96'({regWrite, aluOp, outValid}), 96'(4'b1101));

        step(1, 32'h8CA4_FFFC, 32'h44, 0, 0, hz);
        check("lw_imm", 96'(immediate), 96'(32'hFFFF_FFFC));
        step(1, 32'h0087_3020, 32'h48, 0, 0, hz);
        check("lu_hazard", 96'(hz), 96'(1));
        check("lu_bubble", 96'(outValid), 96'(0));
        step(1, 32'h0087_3020, 32'h48, 0, 0, hz);
        check("lu_release", 96'(hz), 96'(0));
        check("lu_load_r1", 96'({outValid, register1}), 96'({1'b1, 5'd4}));

        step(1, 32'h2020_0005, 32'h4C, 0, 0, hz);
        check("addi0_wr_rw", 96'({writeRegister, regWrite}), 96'(0));
        check("addi0_imm", 96'(immediate), 96'(5));

        step(1, 32'h1022_0003, 32'h50, 0, 0, hz);
        check("beq_branch", 96'(branch), 96'(1));
        step(0, 32'h0, 32'h0, 1, 1, hz);
        check("flush_over_stall", 96'({outValid, branch}), 96'(0));

        // asynchronous reset while a load-use hazard is being signalled
        step(1, 32'h8CA4_FFFC, 32'h60, 0, 0, hz);
        inValid = 1; instruction = 32'h0087_3020; pc = 32'h64;
        #1;
        check("pre_reset_hazard", 96'(hazardStall), 96'(1));
        reset = 1;
        #1;
        m = '0;
        check_state("async_reset_regs");
        check("async_reset_hazard", 96'(hazardStall), 96'(0));
        @(negedge clock);
        reset = 0;

`ifdef IF_ID_ILLEGAL_TRAP_EN
        step(1, 32'hFC00_0000, 32'h70, 0, 0, hz);
        check("trap_set", 96'({illegalInstr, regWrite, memRead, memWrite, branch, jump}),
              96'(6'b100000));
        step(1, 32'hACA4_0008, 32'h74, 0, 0, hz);
        check("trap_clear", 96'({illegalInstr, memWrite}), 96'(2'b01));
`endif

        for (int n = 0; n < 400; n++) begin
            logic [5:0]  opc;
            logic [31:0] ins;
            case ($urandom_range(0, 7))
                0: opc = 6'h00; 1: opc = 6'h23; 2: opc = 6'h2B; 3: opc = 6'h04;
                4: opc = 6'h08; 5: opc = 6'h02; 6: opc = 6'h23; default: opc = 6'(
                    $urandom_range(9, 63));
            endcase
            ins = {opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 11'($urandom)};
            step($urandom_range(0, 7) != 0, ins, $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, hz);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_decode.md
Name: if_id_decode

Overview:
- IF/ID pipeline stage that sits directly upstream of the register file.
- It registers the fetched MIPS instruction and its PC, then decodes the instruction into the register file's read and write selectors (register1, register2, writeRegister), the control signals, and a sign-extended immediate.
- It also detects load-use hazards against the instruction it currently holds, inserts a bubble, and tells fetch to hold.

Parameters:
- PC_WIDTH, 32, width of the program counter carried alongside the instruction.
- INSTR_WIDTH, 32, instruction width; fixed MIPS-I field layout, only 32 is supported.

Ports:
- clock  input  1  stage clock, rising edge.
- reset  input  1  asynchronous, active-high; clears the stage.
- inValid  input  1  instruction/pc are valid this cycle.
- instruction  input  32  fetched instruction word.
- pc  input  PC_WIDTH  PC of the fetched instruction.
- stall  input  1  downstream hold; the stage keeps its contents.
- flush  input  1  branch/jump redirect; the stage becomes a bubble.
- hazardStall  output  1  combinational load-use detect; fetch must hold pc/instruction.
- outValid  output  1  stage holds a real instruction.
- pcOut  output  PC_WIDTH  registered pc.
- register1  output  5  rs field, instr[25:21].
- register2  output  5  rt field, instr[20:16].
- writeRegister  output  5  destination register: rd for R-type, rt for I-type, 0 otherwise.
- immediate  output  32  sign-extended instr[15:0].
- regWrite, memRead, memWrite, memToReg, aluSrc, branch, jump  output  1 each  control signals.
- aluOp  output  2  00 add, 01 sub, 10 funct-decoded.

Behaviour:
- Reset: every registered output is 0 (outValid=0, pcOut=0, all fields, immediate and controls 0). hazardStall is therefore 0 while reset is held.
- Latency: 1 cycle from a load to registered outputs. All outputs except hazardStall come straight from flops, with decode done before the flop.
- Edge priority: reset > flush > hold > load.
  - flush: outValid=0 and all controls 0. Fields and pcOut are don't-care and are zeroed. flush overrides stall and hazardStall in the same cycle.
  - hold (stall=1): all registers unchanged.
  - bubble (hazardStall=1, stall=0): outValid=0, controls 0, pcOut and fields unchanged. The input is not consumed and fetch re-presents it.
  - load (inValid=1): latch pc, decode instruction, outValid=1.
  - inValid=0 with no other event: bubble.
- Decode, by opcode instr[31:26]:
  - 0x00 R-type: regWrite=1, aluOp=10, writeRegister=rd.
  - 0x23 lw: regWrite, memRead, memToReg, aluSrc=1, aluOp=00, writeRegister=rt.
  - 0x2B sw: memWrite, aluSrc=1, aluOp=00.
  - 0x04 beq: branch=1, aluOp=01.
  - 0x08 addi: regWrite, aluSrc=1, aluOp=00, writeRegister=rt.
  - 0x02 j: jump=1.
  - Any other opcode is illegal: all controls 0, outValid=1.
- Register 0 rule: if the decoded writeRegister==0, regWrite is forced 0.
- Load-use hazard: hazardStall = outValid & memRead & (writeRegister!=0) & incoming inValid & ((rs_in==writeRegister) | (usesRt_in & rt_in==writeRegister)).
  - usesRt_in is 1 for R-type, sw and beq.
  - A hazard produces exactly one bubble: the held register becomes non-lw, so hazardStall drops next cycle.
- stall=1 with a hazard present: hold wins and hazardStall stays asserted.
- Reset mid-stall or mid-hazard: the stage clears immediately (asynchronous). No state survives.

Optional Feature:
- Macro: IF_ID_ILLEGAL_TRAP_EN.
- Defined: adds output illegalInstr (1 bit). It is registered, set on load of an unsupported opcode, and cleared on the next load or flush; reset value 0. Decode of the illegal word is unchanged (controls 0).
- Undefined: the port does not exist and illegal opcodes decode silently as no-ops.

Test Plan:
- Reset, then load add $3,$1,$2 (0x00221820) -> next cycle: register1=1, register2=2, writeRegister=3, regWrite=1, aluOp=10, outValid=1.
- Load lw $4,-4($5) (0x8CA4FFFC), then next add $6,$4,$7 -> hazardStall=1 for one cycle and one bubble (outValid=0). The add then loads with register1=4.
- Load addi $0,$1,5 (0x20200005) -> writeRegister=0, regWrite=0, immediate=0x00000005.
- stall=1 and flush=1 in the same cycle after a valid beq -> outValid=0, branch=0.
- Assert reset while hazardStall=1 -> all outputs 0 and hazardStall=0 immediately.
- With IF_ID_ILLEGAL_TRAP_EN defined, load opcode 0x3F -> illegalInstr=1 and controls 0. A following valid sw clears illegalInstr and sets memWrite=1.
